// File: rtl/loader_pkg.sv
// loader_pkg: shared types and sizing for the instruction RAM program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS = 2 ** 10;
    function automatic logic [16:0] max_words(input int addr_w);
        return 17'(1) << addr_w;
    endfunction
endpackage

// File: rtl/mem_inst_loader_word_packer.sv
// word_packer: big-endian byte-to-word shift register with a one-cycle full strobe.
module word_packer
    import loader_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [7:0]                   byte_in,
    input  logic                         shift,
    input  logic                         clear,
    output logic [BYTES_PER_WORD*8-1:0]  word,
    output logic                         word_full
);
    localparam int WORD_W = BYTES_PER_WORD * 8;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    always_comb begin
        word_d = clear ? '0 : shift ? {word_q[WORD_W-9:0], byte_in} : word_q;
        cnt_d  = clear ? '0 : cnt_q + 2'(shift);
        full_d = !clear && shift && cnt_q == 2'(BYTES_PER_WORD - 1);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end
    assign word      = word_q;
    assign word_full = full_q;
endmodule

// File: rtl/mem_inst_loader.sv
// mem_inst_loader: framed byte stream to instruction RAM writer; holds the CPU until a verified load.
module mem_inst_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    state_e              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W+2:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          csum_q, csum_d;
    logic                in_ready_q, in_ready_d, cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d, error_q, error_d;
    logic                accept, go, len_ok, last_byte, shift, word_full;
    logic [15:0]         n;
    logic [BYTES_PER_WORD*8-1:0] word;

    word_packer u_packer (
        .clock     (clock),
        .reset_n   (reset_n),
        .byte_in   (in_byte),
        .shift     (shift),
        .clear     (go),
        .word      (word),
        .word_full (word_full)
    );

    assign accept    = in_valid && in_ready_q;
    assign go        = start && state_q inside {IDLE, DONE, ERROR};
    assign n         = {len_hi_q, in_byte};
    assign len_ok    = n != 16'd0 && {1'b0, n} <= max_words(ADDR_W);
    assign last_byte = cnt_q == {len_q, 2'b00} - (ADDR_W + 3)'(1);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        shift    = 1'b0;
        // address advances in the cycle the word is presented, so it stays valid alongside mem_wren
        addr_d   = addr_q + ADDR_W'(word_full);
        if (go) begin
            state_d = LEN_HI;
            cnt_d   = '0;
            csum_d  = '0;
            addr_d  = '0;
        end else if (accept) begin
            case (state_q)
                LEN_HI: begin
                    len_hi_d = in_byte;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    len_d   = (ADDR_W + 1)'(n);
                    state_d = len_ok ? DATA : ERROR;
                end
                DATA: begin
                    shift   = 1'b1;
                    csum_d  = csum_q ^ in_byte;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_byte ? CHECK : DATA;
                end
                CHECK:   state_d = in_byte == csum_q ? DONE : ERROR;
                default: state_d = state_q;
            endcase
        end
        in_ready_d = state_d inside {LEN_HI, LEN_LO, DATA, CHECK};
        cpu_hold_d = !(state_d inside {IDLE, DONE});
        done_d     = state_d == DONE;
        error_d    = state_d == ERROR;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            csum_q     <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign cpu_hold    = cpu_hold_q;
    assign done        = done_q;
    assign error       = error_q;
    assign mem_address = addr_q;
    assign mem_data    = DATA_W'(word);
    assign mem_wren    = word_full;
endmodule
